// File: rtl/axi_icache_if.sv
// AXI4 bus bundle (AW, W, B, AR, R) shared by the IFU-facing and memory-facing
// sides of the instruction cache.
interface axi_icache_if #(
   parameter int DW = 32
);
   logic          awready;
   logic          awvalid;
   logic [DW-1:0] awaddr;
   logic [3:0]    awid;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic          wready;
   logic          wvalid;
   logic [DW-1:0] wdata;
   logic [DW/8-1:0] wstrb;
   logic          wlast;
   logic          bready;
   logic          bvalid;
   logic [1:0]    bresp;
   logic [3:0]    bid;
   logic          arready;
   logic          arvalid;
   logic [DW-1:0] araddr;
   logic [3:0]    arid;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          rready;
   logic          rvalid;
   logic [1:0]    rresp;
   logic [DW-1:0] rdata;
   logic          rlast;
   logic [3:0]    rid;

   modport master (
      input  awready, output awvalid, awaddr, awid, awlen, awsize, awburst,
      input  wready,  output wvalid, wdata, wstrb, wlast,
      output bready,  input  bvalid, bresp, bid,
      input  arready, output arvalid, araddr, arid, arlen, arsize, arburst,
      output rready,  input  rvalid, rresp, rdata, rlast, rid
   );

   modport slave (
      output awready, input  awvalid, awaddr, awid, awlen, awsize, awburst,
      output wready,  input  wvalid, wdata, wstrb, wlast,
      input  bready,  output bvalid, bresp, bid,
      output arready, input  arvalid, araddr, arid, arlen, arsize, arburst,
      input  rready,  output rvalid, rresp, rdata, rlast, rid
   );
endinterface

// File: rtl/axi_icache.sv
// Direct-mapped, one-word-per-line instruction cache between an IFU AXI4 port
// and a memory AXI4 port; writes bypass the cache entirely.
module axi_icache #(
   parameter int CPU_WIDTH = 32,
   parameter int NLINES    = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   axi_icache_if.slave   ifu,
   axi_icache_if.master  icache
);
   localparam int IDX_W = $clog2(NLINES);
   localparam int TAG_W = CPU_WIDTH - IDX_W - 2;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOOKUP  = 3'd1;
   localparam logic [2:0] S_MISS_AR = 3'd2;
   localparam logic [2:0] S_MISS_R  = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [2:0]           state_q, state_d;
   logic [CPU_WIDTH-1:0] addr_q, addr_d;
   logic [CPU_WIDTH-1:0] data_q, data_d;
   logic [3:0]           id_q, id_d;
   logic [1:0]           resp_q, resp_d;
   logic                 bad_q, bad_d;
   logic [NLINES-1:0]    valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q  [NLINES];
   logic [TAG_W-1:0]     tag_d  [NLINES];
   logic [CPU_WIDTH-1:0] line_q [NLINES];
   logic [CPU_WIDTH-1:0] line_d [NLINES];

   logic [IDX_W-1:0] idx_s;
   logic [TAG_W-1:0] tag_s;
   logic             hit_s;
   logic             ar_bad_s;

   assign idx_s = addr_q[IDX_W+1:2];
   assign tag_s = addr_q[CPU_WIDTH-1:IDX_W+2];
   assign hit_s = valid_q[idx_s] && (tag_q[idx_s] == tag_s);

   // Unsupported burst shapes are answered with SLVERR instead of touching memory.
   assign ar_bad_s = (ifu.arlen != 8'd0) || (ifu.arsize != 3'd2) ||
                     (ifu.arburst != 2'b01) || (ifu.araddr[1:0] != 2'b00);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      id_d    = id_q;
      data_d  = data_q;
      resp_d  = resp_q;
      bad_d   = bad_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      line_d  = line_q;
      case (state_q)
         S_IDLE: begin
            if (ifu.arvalid) begin
               addr_d  = ifu.araddr;
               id_d    = ifu.arid;
               bad_d   = ar_bad_s;
               state_d = S_LOOKUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOOKUP: begin
            if (bad_q) begin
               data_d  = {CPU_WIDTH{1'b0}};
               resp_d  = RESP_SLVERR;
               state_d = S_RESP;
            end else if (hit_s) begin
               data_d  = line_q[idx_s];
               resp_d  = RESP_OKAY;
               state_d = S_RESP;
            end else begin
               state_d = S_MISS_AR;
            end
         end
         S_MISS_AR: begin
            if (icache.arready) begin
               state_d = S_MISS_R;
            end else begin
               state_d = S_MISS_AR;
            end
         end
         S_MISS_R: begin
            if (icache.rvalid && icache.rlast) begin
               data_d  = icache.rdata;
               resp_d  = icache.rresp;
               state_d = S_RESP;
               // Only a clean fill may allocate; an error leaves the line untouched.
               if (icache.rresp == RESP_OKAY) begin
                  valid_d[idx_s] = 1'b1;
                  tag_d[idx_s]   = tag_s;
                  line_d[idx_s]  = icache.rdata;
               end else begin
                  valid_d = valid_q;
               end
            end else begin
               state_d = S_MISS_R;
            end
         end
         S_RESP: begin
            if (ifu.rready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         addr_q  <= {CPU_WIDTH{1'b0}};
         data_q  <= {CPU_WIDTH{1'b0}};
         id_q    <= 4'd0;
         resp_q  <= 2'b00;
         bad_q   <= 1'b0;
         valid_q <= {NLINES{1'b0}};
         for (int i = 0; i < NLINES; i++) begin
            tag_q[i]  <= {TAG_W{1'b0}};
            line_q[i] <= {CPU_WIDTH{1'b0}};
         end
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         id_q    <= id_d;
         resp_q  <= resp_d;
         bad_q   <= bad_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         line_q  <= line_d;
      end
   end

   assign ifu.arready     = (state_q == S_IDLE);
   assign ifu.rvalid      = (state_q == S_RESP);
   assign ifu.rlast       = (state_q == S_RESP);
   assign ifu.rdata       = data_q;
   assign ifu.rresp       = resp_q;
   assign ifu.rid         = id_q;

   assign icache.arvalid  = (state_q == S_MISS_AR);
   assign icache.araddr   = addr_q;
   assign icache.arid     = id_q;
   assign icache.arlen    = 8'd0;
   assign icache.arsize   = 3'd2;
   assign icache.arburst  = 2'b01;
   assign icache.rready   = (state_q == S_MISS_R);

   // Write path is a pure wire-through in both directions.
   assign icache.awvalid  = ifu.awvalid;
   assign icache.awaddr   = ifu.awaddr;
   assign icache.awid     = ifu.awid;
   assign icache.awlen    = ifu.awlen;
   assign icache.awsize   = ifu.awsize;
   assign icache.awburst  = ifu.awburst;
   assign icache.wvalid   = ifu.wvalid;
   assign icache.wdata    = ifu.wdata;
   assign icache.wstrb    = ifu.wstrb;
   assign icache.wlast    = ifu.wlast;
   assign icache.bready   = ifu.bready;
   assign ifu.awready     = icache.awready;
   assign ifu.wready      = icache.wready;
   assign ifu.bvalid      = icache.bvalid;
   assign ifu.bresp       = icache.bresp;
   assign ifu.bid         = icache.bid;
endmodule

// File: tb/tb_axi_icache.sv
// Bench for axi_icache: a word-indexed memory model answers the cache's AXI
// master port; IFU read results go through an expectation queue.
module tb_axi_icache;
   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic [3:0]  id;
   } exp_t;

   logic clk;
   logic rst;
   int   tests_run = 0;
   int   failed    = 0;
   exp_t exp_q[$];

   logic        mem_stall = 1'b0;
   logic        err_en    = 1'b0;
   int          ar_cnt    = 0;
   logic [31:0] last_araddr = 32'd0;
   logic [7:0]  last_arlen  = 8'd0;
   logic [3:0]  last_arid   = 4'd0;
   logic        pend;
   logic [31:0] pend_addr;
   logic [3:0]  pend_id;

   axi_icache_if #(.DW(32)) ifu_bus ();
   axi_icache_if #(.DW(32)) mem_bus ();

   axi_icache #(.CPU_WIDTH(32), .NLINES(16)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .ifu    (ifu_bus),
      .icache (mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: word at byte address 4*j holds j; single-beat reads only.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_bus.arready <= 1'b0;
         mem_bus.rvalid  <= 1'b0;
         mem_bus.rdata   <= 32'd0;
         mem_bus.rresp   <= 2'b00;
         mem_bus.rlast   <= 1'b0;
         mem_bus.rid     <= 4'd0;
         pend            <= 1'b0;
         pend_addr       <= 32'd0;
         pend_id         <= 4'd0;
      end else begin
         mem_bus.arready <= ($urandom_range(0, 3) != 0);
         if (mem_bus.arvalid && mem_bus.arready) begin
            ar_cnt      <= ar_cnt + 1;
            last_araddr <= mem_bus.araddr;
            last_arlen  <= mem_bus.arlen;
            last_arid   <= mem_bus.arid;
            pend        <= 1'b1;
            pend_addr   <= mem_bus.araddr;
            pend_id     <= mem_bus.arid;
         end
         if (mem_bus.rvalid && mem_bus.rready) begin
            mem_bus.rvalid <= 1'b0;
         end else if (pend && !mem_bus.rvalid && !mem_stall) begin
            mem_bus.rvalid <= 1'b1;
            mem_bus.rdata  <= pend_addr >> 2;
            mem_bus.rresp  <= (err_en && pend_addr == 32'h20) ? 2'b10 : 2'b00;
            mem_bus.rlast  <= 1'b1;
            mem_bus.rid    <= pend_id;
            pend           <= 1'b0;
         end
      end
   end

   task automatic ifu_read(input logic [31:0] a, input logic [3:0] id,
                           output logic [38:0] beat, output int lat, output int arn);
      int c0;
      int n;
      c0   = ar_cnt;
      beat = '0;
      @(negedge clk);
      ifu_bus.arvalid = 1'b1;
      ifu_bus.araddr  = a;
      ifu_bus.arid    = id;
      ifu_bus.arlen   = 8'd0;
      ifu_bus.arsize  = 3'd2;
      ifu_bus.arburst = 2'b01;
      n = 0;
      while (!ifu_bus.arready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      ifu_bus.arvalid = 1'b0;
      lat = 1;
      while (!ifu_bus.rvalid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!ifu_bus.rvalid) begin
         tests_run++;
         failed++;
         $display("FAIL read_timeout addr=%h got no rvalid, required rvalid=1", a);
         lat = -1;
      end else begin
         beat = {ifu_bus.rdata, ifu_bus.rresp, ifu_bus.rid, ifu_bus.rlast};
         ifu_bus.rready = 1'b1;
         @(negedge clk);
         ifu_bus.rready = 1'b0;
      end
      arn = ar_cnt - c0;
   endtask

   task automatic test_reset();
      tests_run++;
      if ({ifu_bus.arready, ifu_bus.rvalid, mem_bus.arvalid, mem_bus.rready,
           ifu_bus.rid, ifu_bus.rdata, ifu_bus.rresp} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 2'd0}) begin
         failed++;
         $display("FAIL reset_outputs got arr=%b rv=%b marv=%b mrr=%b rid=%h rdata=%h, required 1 0 0 0 0 0",
                  ifu_bus.arready, ifu_bus.rvalid, mem_bus.arvalid, mem_bus.rready, ifu_bus.rid, ifu_bus.rdata);
      end
   endtask

   task automatic test_cold_miss();
      logic [38:0] beat; int lat; int arn; exp_t e;
      exp_q.push_back('{32'd4, 2'd0, 4'd3});
      ifu_read(32'h10, 4'd3, beat, lat, arn);
      e = exp_q.pop_front();
      tests_run++;
      if (beat !== {e, 1'b1}) begin failed++; $display("FAIL cold_rbeat got %h required %h", beat, {e, 1'b1}); end
      tests_run++;
      if (arn !== 1) begin failed++; $display("FAIL cold_ar_count got %0d required 1", arn); end
      tests_run++;
      if ({last_araddr, last_arlen, last_arid} !== {32'h10, 8'd0, 4'd3}) begin
         failed++; $display("FAIL cold_ar_fields got %h/%h/%h required 10/00/3", last_araddr, last_arlen, last_arid);
      end
   endtask

   task automatic test_hit();
      logic [38:0] beat; int lat; int arn; exp_t e;
      exp_q.push_back('{32'd4, 2'd0, 4'd5});
      ifu_read(32'h10, 4'd5, beat, lat, arn);
      e = exp_q.pop_front();
      tests_run++;
      if (beat !== {e, 1'b1}) begin failed++; $display("FAIL hit_rbeat got %h required %h", beat, {e, 1'b1}); end
      tests_run++;
      if (arn !== 0) begin failed++; $display("FAIL hit_ar_count got %0d required 0", arn); end
      tests_run++;
      if (lat !== 2) begin failed++; $display("FAIL hit_latency got %0d required 2", lat); end
   endtask

   task automatic test_conflict();
      logic [38:0] beat; int lat; int arn; exp_t e;
      logic [31:0] addrs [2];
      addrs[0] = 32'h50;
      addrs[1] = 32'h10;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back('{addrs[k] >> 2, 2'd0, 4'(k + 6)});
         ifu_read(addrs[k], 4'(k + 6), beat, lat, arn);
         e = exp_q.pop_front();
         tests_run++;
         if (beat !== {e, 1'b1}) begin failed++; $display("FAIL conflict_rbeat[%0d] got %h required %h", k, beat, {e, 1'b1}); end
         tests_run++;
         if (arn !== 1) begin failed++; $display("FAIL conflict_ar_count[%0d] got %0d required 1", k, arn); end
      end
   endtask

   task automatic test_error();
      logic [38:0] beat; int lat; int arn; exp_t e;
      err_en = 1'b1;
      exp_q.push_back('{32'd8, 2'b10, 4'd2});
      ifu_read(32'h20, 4'd2, beat, lat, arn);
      e = exp_q.pop_front();
      tests_run++;
      if (beat !== {e, 1'b1}) begin failed++; $display("FAIL err_rbeat got %h required %h", beat, {e, 1'b1}); end
      err_en = 1'b0;
      exp_q.push_back('{32'd8, 2'b00, 4'd4});
      ifu_read(32'h20, 4'd4, beat, lat, arn);
      e = exp_q.pop_front();
      tests_run++;
      if (arn !== 1) begin failed++; $display("FAIL err_reread_ar_count got %0d required 1", arn); end
      tests_run++;
      if (beat !== {e, 1'b1}) begin failed++; $display("FAIL err_reread_rbeat got %h required %h", beat, {e, 1'b1}); end
   endtask

   task automatic test_write();
      logic [38:0] beat; int lat; int arn; exp_t e;
      @(negedge clk);
      ifu_bus.awvalid = 1'b1; ifu_bus.awaddr = 32'h30; ifu_bus.awid = 4'h7;
      ifu_bus.awlen = 8'd0; ifu_bus.awsize = 3'd2; ifu_bus.awburst = 2'b01;
      ifu_bus.wvalid = 1'b1; ifu_bus.wdata = 32'hAA; ifu_bus.wstrb = 4'hF; ifu_bus.wlast = 1'b1;
      ifu_bus.bready = 1'b1;
      mem_bus.awready = 1'b1; mem_bus.wready = 1'b0;
      mem_bus.bvalid = 1'b1; mem_bus.bresp = 2'b01; mem_bus.bid = 4'h7;
      #1;
      tests_run++;
      if ({mem_bus.awvalid, mem_bus.awaddr, mem_bus.awid, mem_bus.awlen, mem_bus.awsize, mem_bus.awburst}
          !== {1'b1, 32'h30, 4'h7, 8'd0, 3'd2, 2'b01}) begin
         failed++; $display("FAIL wr_aw_pass got addr=%h id=%h required addr=30 id=7", mem_bus.awaddr, mem_bus.awid);
      end
      tests_run++;
      if ({mem_bus.wvalid, mem_bus.wdata, mem_bus.wstrb, mem_bus.wlast} !== {1'b1, 32'hAA, 4'hF, 1'b1}) begin
         failed++; $display("FAIL wr_w_pass got data=%h strb=%h required data=aa strb=f", mem_bus.wdata, mem_bus.wstrb);
      end
      tests_run++;
      if ({ifu_bus.awready, ifu_bus.wready, ifu_bus.bvalid, ifu_bus.bresp, ifu_bus.bid, mem_bus.bready}
          !== {1'b1, 1'b0, 1'b1, 2'b01, 4'h7, 1'b1}) begin
         failed++; $display("FAIL wr_back_pass got awr=%b wr=%b bresp=%b bid=%h required 1 0 01 7",
                            ifu_bus.awready, ifu_bus.wready, ifu_bus.bresp, ifu_bus.bid);
      end
      @(negedge clk);
      ifu_bus.awvalid = 1'b0; ifu_bus.wvalid = 1'b0; ifu_bus.bready = 1'b0;
      mem_bus.awready = 1'b0; mem_bus.bvalid = 1'b0;
      exp_q.push_back('{32'd4, 2'd0, 4'd1});
      ifu_read(32'h10, 4'd1, beat, lat, arn);
      e = exp_q.pop_front();
      tests_run++;
      if ({beat, arn} !== {e, 1'b1, 32'd0}) begin
         failed++; $display("FAIL wr_cache_kept got beat=%h ar=%0d required %h ar=0", beat, arn, {e, 1'b1});
      end
   endtask

   task automatic test_reset_mid();
      logic [38:0] beat; int lat; int arn; exp_t e; int n;
      mem_stall = 1'b1;
      @(negedge clk);
      ifu_bus.arvalid = 1'b1; ifu_bus.araddr = 32'h40; ifu_bus.arid = 4'd9;
      n = 0;
      while (!ifu_bus.arready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      ifu_bus.arvalid = 1'b0;
      n = 0;
      while (!mem_bus.rready && n < 100) begin @(negedge clk); n++; end
      tests_run++;
      if (mem_bus.rready !== 1'b1) begin failed++; $display("FAIL mid_reach_miss_r got rready=%b required 1", mem_bus.rready); end
      rst = 1'b1;
      #1;
      test_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mem_stall = 1'b0;
      exp_q.push_back('{32'd4, 2'd0, 4'd2});
      ifu_read(32'h10, 4'd2, beat, lat, arn);
      e = exp_q.pop_front();
      tests_run++;
      if ({beat, arn} !== {e, 1'b1, 32'd1}) begin
         failed++; $display("FAIL mid_post_reset_0x10 got beat=%h ar=%0d required %h ar=1", beat, arn, {e, 1'b1});
      end
      exp_q.push_back('{32'd16, 2'd0, 4'd9});
      ifu_read(32'h40, 4'd9, beat, lat, arn);
      e = exp_q.pop_front();
      tests_run++;
      if ({beat, arn} !== {e, 1'b1, 32'd1}) begin
         failed++; $display("FAIL mid_no_partial_0x40 got beat=%h ar=%0d required %h ar=1", beat, arn, {e, 1'b1});
      end
   endtask

   initial begin
      rst = 1'b1;
      ifu_bus.awvalid = 1'b0; ifu_bus.awaddr = 32'd0; ifu_bus.awid = 4'd0; ifu_bus.awlen = 8'd0;
      ifu_bus.awsize = 3'd0; ifu_bus.awburst = 2'd0; ifu_bus.wvalid = 1'b0; ifu_bus.wdata = 32'd0;
      ifu_bus.wstrb = 4'd0; ifu_bus.wlast = 1'b0; ifu_bus.bready = 1'b0;
      ifu_bus.arvalid = 1'b0; ifu_bus.araddr = 32'd0; ifu_bus.arid = 4'd0; ifu_bus.arlen = 8'd0;
      ifu_bus.arsize = 3'd2; ifu_bus.arburst = 2'b01; ifu_bus.rready = 1'b0;
      mem_bus.awready = 1'b0; mem_bus.wready = 1'b0; mem_bus.bvalid = 1'b0;
      mem_bus.bresp = 2'd0; mem_bus.bid = 4'd0;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      test_cold_miss();
      test_hit();
      test_conflict();
      test_error();
      test_write();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end
endmodule
